uart_mem_loader: RTL and testbench

Initiator-side memory write engine for the single-cycle CPU's data/program memory. It consumes a byte stream from the UART receiver and assembles bytes little-endian into 32-bit words. Each word goes out as a one-cycle write (address, write data, write enable) on the same port interface the data memory exposes. It sits between the UART RX block and the memory's write mux, and owns that port only while a load is in progress.

---
 rtl/loader_pkg.sv | 14 +
 rtl/word_assembler.sv | 32 +++
 rtl/uart_mem_loader.sv | 96 +++++++++
 tb/tb_uart_mem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the UART memory loader and the data memory it feeds.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    localparam int MEM_WORD_ADDR_BITS = 14;
    localparam int BYTES_PER_WORD     = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs an incoming byte stream little-endian into 32-bit words and flags the
// cycle on which the fourth byte of a word arrives.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] byte_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (byte_valid) begin
            word[8*byte_idx +: 8] <= byte_data;
            byte_idx              <= byte_idx + 2'd1;
        end
    end

    // Fires with the last byte so the controller can enter its write cycle on the same edge.
    assign word_complete = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/uart_mem_loader.sv
// Memory write engine: turns the UART RX byte stream into one-cycle word writes
// on the data memory port, with an idle timeout that aborts unfinished loads.
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned LOAD_WORDS     = 16384,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [14:0] word_count
);

    localparam int CW = MEM_WORD_ADDR_BITS + 1;

    state_t      state, state_next;
    logic        accept;
    logic        word_complete;
    logic        start_ok;
    logic        tmo_hit;
    logic        last_word;
    logic [31:0] tmo_cnt;

    assign start_ok  = (state == ST_IDLE) && start;
    assign tmo_hit   = (state == ST_COLLECT) && !rx_valid && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign last_word = (word_count == CW'(LOAD_WORDS - 1));

    word_assembler u_word_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (start_ok),
        .byte_valid    (accept),
        .byte_data     (rx_data),
        .word          (mem_write_data),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_ok) state_next = ST_COLLECT;
            ST_COLLECT: begin
                if (word_complete)  state_next = ST_WRITE;
                else if (tmo_hit)   state_next = ST_IDLE;
            end
            ST_WRITE:   state_next = last_word ? ST_FINISH : ST_COLLECT;
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Bytes landing during the write cycle already belong to the next word.
    always_comb begin
        busy      = (state != ST_IDLE);
        mem_write = (state == ST_WRITE);
        accept    = rx_valid && ((state == ST_COLLECT) || (state == ST_WRITE));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (start_ok) begin
                word_count <= '0;
                done       <= 1'b0;
                timeout    <= 1'b0;
            end
            if (state == ST_WRITE)  word_count <= word_count + 1'b1;
            if (state == ST_FINISH) done <= 1'b1;
            if (tmo_hit)            timeout <= 1'b1;
            if ((state == ST_COLLECT) && !rx_valid) tmo_cnt <= tmo_cnt + 32'd1;
            else                                    tmo_cnt <= '0;
        end
    end

    assign mem_address = BASE_ADDR + 32'({word_count, 2'b00});

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: directed byte streams, expected writes
// queued at stimulus time and matched by a negedge write monitor.
module tb_uart_mem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [14:0] word_count;

    uart_mem_loader #(
        .LOAD_WORDS     (3),
        .BASE_ADDR      (32'h0000_0100),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .word_count     (word_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cycles[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_write) begin
            wr_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_write addr=%h data=%h required=no write", mem_address, mem_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_address !== e.addr || mem_write_data !== e.data) begin
                    errors++;
                    $display("FAIL mem_write actual=%h@%h required=%h@%h",
                             mem_write_data, mem_address, e.data, e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[]);
        foreach (b[i]) send_byte(b[i]);
    endtask

    initial begin
        logic [7:0] seq1[];
        logic [7:0] seq3[];
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        #12;
        chk("rst_mem_write",  32'(mem_write),  32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_done",       32'(done),       32'h0);
        chk("rst_timeout",    32'(timeout),    32'h0);
        chk("rst_word_count", 32'(word_count), 32'h0);
        chk("rst_address",    mem_address,     32'h0000_0100);
        chk("rst_data",       mem_write_data,  32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Load 1: little-endian assembly, continuous bytes including during WRITE.
        expect_wr(32'h100, 32'h1234_5678);
        expect_wr(32'h104, 32'hDEAD_BEEF);
        expect_wr(32'h108, 32'h1122_3344);
        pulse_start();
        chk("l1_busy_after_start", 32'(busy), 32'h1);
        seq1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h44, 8'h33, 8'h22, 8'h11};
        send_bytes(seq1);
        repeat (4) tick();
        chk("l1_done",       32'(done),       32'h1);
        chk("l1_busy",       32'(busy),       32'h0);
        chk("l1_word_count", 32'(word_count), 32'd3);
        chk("l1_timeout",    32'(timeout),    32'h0);

        // Load 2: groups of four back-to-back bytes with one idle cycle between.
        wr_cycles.delete();
        expect_wr(32'h100, 32'h0302_0100);
        expect_wr(32'h104, 32'h0706_0504);
        expect_wr(32'h108, 32'h0B0A_0908);
        pulse_start();
        chk("l2_done_cleared", 32'(done), 32'h0);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(w * 4 + b));
            tick();
        end
        repeat (3) tick();
        chk("l2_nwrites", 32'(wr_cycles.size()), 32'd3);
        if (wr_cycles.size() >= 3) begin
            chk("l2_spacing01", 32'(wr_cycles[1] - wr_cycles[0]), 32'd5);
            chk("l2_spacing12", 32'(wr_cycles[2] - wr_cycles[1]), 32'd5);
        end
        chk("l2_done",       32'(done),       32'h1);
        chk("l2_word_count", 32'(word_count), 32'd3);

        // Timeout: two bytes then silence; abort lands on the tenth idle edge.
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (9) tick();
        chk("tmo_busy_edge9",    32'(busy),    32'h1);
        chk("tmo_timeout_edge9", 32'(timeout), 32'h0);
        tick();
        chk("tmo_timeout",    32'(timeout),    32'h1);
        chk("tmo_busy",       32'(busy),       32'h0);
        chk("tmo_word_count", 32'(word_count), 32'h0);
        chk("tmo_done",       32'(done),       32'h0);

        // Bytes while idle are ignored.
        for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
        repeat (2) tick();
        chk("idle_word_count", 32'(word_count), 32'h0);
        chk("idle_busy",       32'(busy),       32'h0);
        chk("idle_address",    mem_address,     32'h0000_0100);
        chk("idle_timeout",    32'(timeout),    32'h1);

        // Start pulse in the middle of a word must not disturb it.
        expect_wr(32'h100, 32'hD3C2_B1A0);
        expect_wr(32'h104, 32'h1312_1110);
        expect_wr(32'h108, 32'h1716_1514);
        pulse_start();
        chk("sb_timeout_cleared", 32'(timeout), 32'h0);
        send_byte(8'hA0);
        send_byte(8'hB1);
        pulse_start();
        send_byte(8'hC2);
        send_byte(8'hD3);
        tick();
        chk("sb_word_count1", 32'(word_count), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        repeat (4) tick();
        chk("sb_done",       32'(done),       32'h1);
        chk("sb_word_count", 32'(word_count), 32'd3);

        // Reset after five bytes of a load.
        expect_wr(32'h100, 32'h1234_5678);
        pulse_start();
        seq3 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        send_bytes(seq3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_write",  32'(mem_write),  32'h0);
        chk("mid_rst_busy",       32'(busy),       32'h0);
        chk("mid_rst_word_count", 32'(word_count), 32'h0);
        chk("mid_rst_address",    mem_address,     32'h0000_0100);
        chk("mid_rst_done",       32'(done),       32'h0);
        tick();
        reset = 1'b0;

        // Reset during the write cycle drops mem_write before the memory edge.
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
        chk("wr_rst_pre_mem_write", 32'(mem_write), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("wr_rst_mem_write", 32'(mem_write), 32'h0);
        tick();
        reset = 1'b0;

        // Fresh load after reset starts at the base address and byte lane 0.
        expect_wr(32'h100, 32'h4433_2211);
        expect_wr(32'h104, 32'h8877_6655);
        expect_wr(32'h108, 32'hCCBB_AA99);
        pulse_start();
        for (int i = 1; i <= 12; i++) send_byte(8'(i * 8'h11));
        repeat (4) tick();
        chk("post_rst_done",       32'(done),       32'h1);
        chk("post_rst_word_count", 32'(word_count), 32'd3);

        repeat (2) tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
